harvard_core: RTL and testbench
===============================

HARVARD_CORE -- requirements
Module: harvard_core

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 counter  output  6  Program counter, i.e. the current instruction address.
REQ-004 instruction_out  output  32  Instruction word read from ROM at address counter.
REQ-005 out  output  32  Registered ALU result.

Function
REQ-006 The block SHALL contain three parts: a 6-bit program counter, a 64x32 instruction ROM, and an ALU with a registered output.
REQ-007 The counter SHALL increment by 1 on every rising clk edge while reset is low.
REQ-008 The counter SHALL wrap from 63 to 0 with no flag and no stall.
REQ-009 The ROM SHALL be a combinational read: instruction_out = ROM[counter], valid in the same cycle with no clock latency.
REQ-010 Instruction format SHALL be: opcode = instr[31:24]; A = instr[23:12] zero-extended to 32 bits; B = instr[11:0] zero-extended to 32 bits.
REQ-011 ALU opcodes SHALL be:
- 0x00 ADD: A+B
- 0x01 SUB: A-B, mod 2^32, so underflow wraps
- 0x02 AND
- 0x03 OR
- 0x04 XOR
- 0x05 NOT A (32-bit invert)
- 0x06 SHL: A << B[4:0]
- 0x07 SHR: logical A >> B[4:0]
- 0x08 MUL: A*B (24-bit product, zero-extended)
- 0x09 PASS A
- 0x0A SLT: 1 if A<B unsigned, else 0
REQ-012 Any other opcode SHALL produce 0.
REQ-013 All arithmetic SHALL be unsigned and truncated to 32 bits; there are no carry or overflow outputs.
REQ-014 On each rising edge with reset low, out SHALL load the ALU result of the instruction present before the edge, i.e. of ROM[old counter].
REQ-015 Latency: after the k-th post-reset edge (k>=1), counter = k mod 64 and out = result(ROM[(k-1) mod 64]).
REQ-016 The counter increment and the out register SHALL update on the same edge; no handshake or enable exists.
REQ-017 ROM contents SHALL be fixed at elaboration:
- [0] = 0x00005003 (ADD 5,3)
- [1] = 0x0100A004 (SUB 10,4)
- [2] = 0x0200C00A (AND)
- [3] = 0x0300C00A (OR)
- [4] = 0x0400C00A (XOR)
- [5] = 0x05000000 (NOT 0)
- [6] = 0x06001004 (SHL 1,4)
- [7] = 0x08007006 (MUL 7,6)
- [8..63] = 0x00000000 (ADD 0,0)

Reset
REQ-018 While reset is high, counter = 0 and out = 0 immediately, regardless of clk.
REQ-019 During reset, instruction_out SHALL show ROM[0] = 0x00005003.
REQ-020 Reset asserted mid-run SHALL clear counter and out asynchronously.
REQ-021 After reset deasserts, the first rising edge SHALL give counter = 1 and out = 8.
REQ-022 Deassertion coincident with a clk edge SHALL NOT be required to count; the first full edge after deassertion is edge 1.

Verification
REQ-023 Hold reset high across 2 clk edges -> counter = 0, out = 0, instruction_out = 0x00005003 throughout.
REQ-024 Release reset, then apply 8 edges -> out sequence 8, 6, 8, 14, 6, 0xFFFFFFFF, 16, 42 and counter sequence 1..8.
REQ-025 Run 64 edges after reset -> counter wraps 63 -> 0 and out = 0 while executing addresses 8..63.
REQ-026 Assert reset between edges at counter = 5 -> counter and out go to 0 before the next edge; after release, the sequence restarts at out = 8.
REQ-027 Force an unused opcode (e.g. 0xFF via a ROM override in the bench) -> out = 0 on the following edge.
REQ-028 Apply SUB with A=3, B=5 -> out = 0xFFFFFFFE.

Source files
------------

// File: rtl/harvard_core.sv
// harvard_core: 6-bit free-running program counter, 64x32 instruction ROM with
// combinational read, and a 12-bit-operand ALU whose result is registered.
// The ROM image is a packed parameter. Word i sits at bits [i*32 +: 32].
module harvard_core #(
   parameter logic [2047:0] ROM_IMAGE = {
      {56{32'h0000_0000}},
      32'h0800_7006,   // [7] MUL 7,6
      32'h0600_1004,   // [6] SHL 1,4
      32'h0500_0000,   // [5] NOT 0
      32'h0400_C00A,   // [4] XOR
      32'h0300_C00A,   // [3] OR
      32'h0200_C00A,   // [2] AND
      32'h0100_A004,   // [1] SUB 10,4
      32'h0000_5003    // [0] ADD 5,3
   }
) (
   input  logic        clk,
   input  logic        reset,
   output logic [5:0]  counter,
   output logic [31:0] instruction_out,
   output logic [31:0] out
);

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_AND = 8'h02;
   localparam logic [7:0] OP_OR  = 8'h03;
   localparam logic [7:0] OP_XOR = 8'h04;
   localparam logic [7:0] OP_NOT = 8'h05;
   localparam logic [7:0] OP_SHL = 8'h06;
   localparam logic [7:0] OP_SHR = 8'h07;
   localparam logic [7:0] OP_MUL = 8'h08;
   localparam logic [7:0] OP_PAS = 8'h09;
   localparam logic [7:0] OP_SLT = 8'h0A;

   logic [5:0]  r_counter;
   logic [31:0] r_out;
   logic [31:0] w_rom [64];
   logic [31:0] w_instr;
   logic [7:0]  w_opcode;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [23:0] w_prod;
   logic [31:0] w_alu;

   // Unpack the ROM image into addressable words.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_rom
         assign w_rom[gi] = ROM_IMAGE[gi*32 +: 32];
      end
   endgenerate

   // Combinational fetch: the word at the current PC is visible in the same cycle.
   assign w_instr         = w_rom[r_counter];
   assign instruction_out = w_instr;

   // Field decode. Both operands are 12-bit fields, zero-extended to 32 bits.
   assign w_opcode = w_instr[31:24];
   assign w_a      = {20'd0, w_instr[23:12]};
   assign w_b      = {20'd0, w_instr[11:0]};
   assign w_prod   = {12'd0, w_instr[23:12]} * {12'd0, w_instr[11:0]};

   // ALU operation select. Undefined opcodes yield zero.
   always_comb begin
      w_alu = 32'd0;
      case (w_opcode)
         OP_ADD:  w_alu = w_a + w_b;
         OP_SUB:  w_alu = w_a - w_b;
         OP_AND:  w_alu = w_a & w_b;
         OP_OR:   w_alu = w_a | w_b;
         OP_XOR:  w_alu = w_a ^ w_b;
         OP_NOT:  w_alu = ~w_a;
         OP_SHL:  w_alu = w_a << w_b[4:0];
         OP_SHR:  w_alu = w_a >> w_b[4:0];
         OP_MUL:  w_alu = {8'd0, w_prod};
         OP_PAS:  w_alu = w_a;
         OP_SLT:  w_alu = {31'd0, (w_a < w_b)};
         default: w_alu = 32'd0;
      endcase
   end

   // PC advance and result capture share one edge. The PC wraps 63 -> 0 naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_counter <= 6'd0;
         r_out     <= 32'd0;
      end else begin
         r_counter <= r_counter + 6'd1;
         r_out     <= w_alu;
      end
   end

   assign counter = r_counter;
   assign out     = r_out;

endmodule

// File: tb/tb_harvard_core.sv
// Scoreboard bench for harvard_core.
// Instance u_dut_a uses the default ROM.
// Instance u_dut_b uses a patched ROM with extra opcodes at addresses 8..16.
// Stimulus pushes expected states into a queue. A monitor pops the queue and
// compares after each clock edge, or on an explicit event for asynchronous
// reset checks.
module tb_harvard_core;

   // Bench-side ROM image with hand-picked instructions at 8..16.
   function automatic logic [2047:0] img_b();
      logic [2047:0] v;
      v = '0;
      v[0*32  +: 32] = 32'h0000_5003;
      v[1*32  +: 32] = 32'h0100_A004;
      v[2*32  +: 32] = 32'h0200_C00A;
      v[3*32  +: 32] = 32'h0300_C00A;
      v[4*32  +: 32] = 32'h0400_C00A;
      v[5*32  +: 32] = 32'h0500_0000;
      v[6*32  +: 32] = 32'h0600_1004;
      v[7*32  +: 32] = 32'h0800_7006;
      v[8*32  +: 32] = 32'hFF00_ABCD;   // unused opcode 0xFF -> 0
      v[9*32  +: 32] = 32'h0100_3005;   // SUB 3,5 -> FFFFFFFE
      v[10*32 +: 32] = 32'h07F0_0004;   // SHR F00>>4 -> F0
      v[11*32 +: 32] = 32'h09AB_C123;   // PASS A=ABC
      v[12*32 +: 32] = 32'h0A00_3005;   // SLT 3<5 -> 1
      v[13*32 +: 32] = 32'h0A00_5003;   // SLT 5<3 -> 0
      v[14*32 +: 32] = 32'h08FF_FFFF;   // MUL FFF*FFF -> FFE001
      v[15*32 +: 32] = 32'h0B00_1001;   // unused opcode 0x0B -> 0
      v[16*32 +: 32] = 32'h0600_1025;   // SHL 1 << (0x25 & 31 = 5) -> 20
      return v;
   endfunction

   localparam logic [2047:0] IMG_B = img_b();

   typedef struct {
      int          dut;
      string       name;
      logic [5:0]  cnt;
      logic [31:0] ins;
      logic [31:0] res;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  cnt_a, cnt_b;
   logic [31:0] ins_a, ins_b, out_a, out_b;

   exp_t exp_q[$];
   event chk_ev;
   int   n_cmp  = 0;
   int   n_fail = 0;

   harvard_core u_dut_a (
      .clk(clk), .reset(reset), .counter(cnt_a),
      .instruction_out(ins_a), .out(out_a)
   );

   harvard_core #(.ROM_IMAGE(IMG_B)) u_dut_b (
      .clk(clk), .reset(reset), .counter(cnt_b),
      .instruction_out(ins_b), .out(out_b)
   );

   always #5 clk = ~clk;

   // Instruction word expected at an address for each instance.
   function automatic logic [31:0] rom_word(int dut, int addr);
      logic [31:0] w;
      w = 32'd0;
      if (dut == 1) begin
         w = IMG_B[addr*32 +: 32];
      end else begin
         case (addr)
            0: w = 32'h0000_5003;
            1: w = 32'h0100_A004;
            2: w = 32'h0200_C00A;
            3: w = 32'h0300_C00A;
            4: w = 32'h0400_C00A;
            5: w = 32'h0500_0000;
            6: w = 32'h0600_1004;
            7: w = 32'h0800_7006;
            default: w = 32'd0;
         endcase
      end
      return w;
   endfunction

   // Hand-computed ALU result of the instruction at an address.
   function automatic logic [31:0] res_word(int dut, int addr);
      logic [31:0] r;
      r = 32'd0;
      case (addr)
         0: r = 32'd8;
         1: r = 32'd6;
         2: r = 32'd8;
         3: r = 32'd14;
         4: r = 32'd6;
         5: r = 32'hFFFF_FFFF;
         6: r = 32'd16;
         7: r = 32'd42;
         default: r = 32'd0;
      endcase
      if (dut == 1) begin
         case (addr)
            9:  r = 32'hFFFF_FFFE;
            10: r = 32'h0000_00F0;
            11: r = 32'h0000_0ABC;
            12: r = 32'd1;
            14: r = 32'h00FF_E001;
            16: r = 32'h0000_0020;
            default: ;
         endcase
      end
      return r;
   endfunction

   // Expect the reset state on both instances.
   task automatic push_reset(string nm);
      for (int d = 0; d < 2; d++)
         exp_q.push_back('{dut: d, name: nm, cnt: 6'd0, ins: 32'h0000_5003, res: 32'd0});
   endtask

   // Expect the state after post-reset edge k on both instances.
   task automatic push_edge(string nm, int k);
      for (int d = 0; d < 2; d++)
         exp_q.push_back('{dut: d, name: $sformatf("%s_k%0d", nm, k),
                           cnt: 6'(k % 64), ins: rom_word(d, k % 64),
                           res: res_word(d, (k - 1) % 64)});
   endtask

   // Monitor: compare after each clock edge or on an explicit check event.
   initial begin
      exp_t e;
      logic [5:0]  ac;
      logic [31:0] ai, ao;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ac = (e.dut == 1) ? cnt_b : cnt_a;
            ai = (e.dut == 1) ? ins_b : ins_a;
            ao = (e.dut == 1) ? out_b : out_a;
            n_cmp++;
            if (ac !== e.cnt || ai !== e.ins || ao !== e.res) begin
               n_fail++;
               $display("FAIL %s dut%0d: got counter=%0d instr=%h out=%h, need counter=%0d instr=%h out=%h",
                        e.name, e.dut, ac, ai, ao, e.cnt, e.ins, e.res);
            end else begin
               $display("ok   %s dut%0d: counter=%0d instr=%h out=%h",
                        e.name, e.dut, ac, ai, ao);
            end
         end
      end
   end

   // Stimulus.
   initial begin
      reset = 1'b1;
      #1;
      push_reset("rst_immediate");
      -> chk_ev;
      #2;

      // Hold reset across two edges.
      push_reset("rst_hold_e1");
      @(negedge clk);
      push_reset("rst_hold_e2");
      @(negedge clk);

      // Release and run past the 63 -> 0 wrap.
      reset = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         push_edge("run", k);
         @(negedge clk);
      end

      // Reset mid-cycle, then restart.
      reset = 1'b1;
      #1;
      push_reset("rst_async_a");
      -> chk_ev;
      #2;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         push_edge("pre", k);
         @(negedge clk);
      end

      // Counter is now 5. Assert reset between edges.
      #2;
      reset = 1'b1;
      #1;
      push_reset("rst_mid_c5");
      -> chk_ev;
      #1;
      push_reset("rst_mid_edge");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         push_edge("restart", k);
         @(negedge clk);
      end

      #3;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL leftover: %0d pending, need 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
